// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl: challenge sequencer for the ring-oscillator PUF.
//
// For each of RESP_BITS oscillator pairs the controller selects oscillator
// (challenge+idx) in bank A and (challenge+idx+16) in bank B, clears both
// edge counters for one cycle, enables the oscillators for WINDOW cycles,
// waits SETTLE cycles for the counters to freeze, then compares the counts
// to produce one response bit.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous reset, active-high (asserted when rst_n == 1)
//   start      begin an evaluation; only looked at while idle
//   abort      synchronous cancel of a running evaluation
//   challenge  base oscillator index, captured when start is accepted
//   count_a    bank A edge count
//   count_b    bank B edge count
//   ro_en      oscillator enable to both banks
//   cnt_clr    counter clear to both banks
//   sel_a      bank A oscillator select
//   sel_b      bank B oscillator select
//   busy       evaluation in progress
//   done       one-cycle pulse, response/tie valid
//   response   last completed response
//   tie        some pair compared equal in the last completed evaluation
module ro_puf_ctrl #(
    parameter int COUNT_W   = 8,
    parameter int WINDOW    = 64,
    parameter int SETTLE    = 4,
    parameter int RESP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [4:0]           challenge,
    input  logic [COUNT_W-1:0]   count_a,
    input  logic [COUNT_W-1:0]   count_b,
    output logic                 ro_en,
    output logic                 cnt_clr,
    output logic [4:0]           sel_a,
    output logic [4:0]           sel_b,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic                 tie
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_COMPARE,
        S_DONE
    } state_t;

    // One timer serves both the RUN window and the SETTLE wait.
    localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW   = $clog2(TMAX + 1);

    state_t                state, nxt;
    logic [TW-1:0]         tmr;
    logic [4:0]            ch_reg;
    logic [4:0]            idx;
    logic [RESP_BITS-1:0]  shreg, shreg_nxt;
    logic                  tie_acc;

    logic last_win, last_set, last_bit, cmp_bit, cmp_eq;

    assign last_win = (tmr == TW'(WINDOW - 1));
    assign last_set = (tmr == TW'(SETTLE - 1));
    assign last_bit = (idx == 5'(RESP_BITS - 1));
    assign cmp_bit  = (count_a > count_b);
    assign cmp_eq   = (count_a == count_b);

    // 5-bit adds wrap modulo 32 on their own; the +16 offset keeps the two
    // selects distinct for any challenge/idx.
    assign sel_a = ch_reg + idx;
    assign sel_b = sel_a + 5'd16;

    assign ro_en   = (state == S_RUN);
    assign cnt_clr = (state == S_CLEAR);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (start && !abort) nxt = S_CLEAR;
            S_CLEAR:   nxt = S_RUN;
            S_RUN:     if (last_win) nxt = S_SETTLE;
            S_SETTLE:  if (last_set) nxt = S_COMPARE;
            S_COMPARE: nxt = last_bit ? S_DONE : S_CLEAR;
            S_DONE:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) nxt = S_IDLE;
    end

    // Shift register with the current comparison merged in at position idx.
    always_comb begin
        shreg_nxt = shreg;
        for (int i = 0; i < RESP_BITS; i++) begin
            if (idx == 5'(i)) shreg_nxt[i] = cmp_bit;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= S_IDLE;
        else       state <= nxt;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tmr      <= '0;
            ch_reg   <= '0;
            idx      <= '0;
            shreg    <= '0;
            tie_acc  <= 1'b0;
            response <= '0;
            tie      <= 1'b0;
        end else begin
            // Timer runs while staying in RUN/SETTLE, restarts on any exit.
            if ((state == S_RUN || state == S_SETTLE) && nxt == state)
                tmr <= tmr + TW'(1);
            else
                tmr <= '0;

            if (state == S_IDLE && nxt == S_CLEAR) begin
                ch_reg  <= challenge;
                idx     <= '0;
                shreg   <= '0;
                tie_acc <= 1'b0;
            end

            // nxt == S_IDLE here means abort: the partial result is dropped.
            if (state == S_COMPARE && nxt != S_IDLE) begin
                shreg   <= shreg_nxt;
                tie_acc <= tie_acc | cmp_eq;
                if (nxt == S_CLEAR) idx <= idx + 5'd1;
                // Publish on entry to DONE so response/tie are valid with done.
                if (nxt == S_DONE) begin
                    response <= shreg_nxt;
                    tie      <= tie_acc | cmp_eq;
                end
            end
        end
    end

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Self-checking bench for ro_puf_ctrl. Counts presented to the DUT come from
// per-oscillator tables indexed by the current bank A select; the expected
// response is computed from the challenge and the same tables.
module tb_ro_puf_ctrl;

    localparam int CW       = 8;
    localparam int WIN      = 64;
    localparam int SET      = 4;
    localparam int RB       = 8;
    localparam int DONE_CYC = RB * (WIN + SET + 2) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [4:0]    challenge = '0;
    logic [CW-1:0] count_a, count_b;
    logic          ro_en, cnt_clr, busy, done, tie;
    logic [4:0]    sel_a, sel_b;
    logic [RB-1:0] response;

    logic [CW-1:0] ta [32];
    logic [CW-1:0] tbv[32];

    int n_vec = 0;
    int n_err = 0;
    logic [RB-1:0] exp_resp = '0;
    logic          exp_tie  = 1'b0;

    ro_puf_ctrl #(.COUNT_W(CW), .WINDOW(WIN), .SETTLE(SET), .RESP_BITS(RB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .challenge(challenge), .count_a(count_a), .count_b(count_b),
        .ro_en(ro_en), .cnt_clr(cnt_clr), .sel_a(sel_a), .sel_b(sel_b),
        .busy(busy), .done(done), .response(response), .tie(tie)
    );

    always #5 clk = ~clk;

    assign count_a = ta[sel_a];
    assign count_b = tbv[sel_a];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [4:0] ch, output logic [RB-1:0] r, output logic t);
        r = '0;
        t = 1'b0;
        for (int i = 0; i < RB; i++) begin
            int s;
            s = (int'(ch) + i) % 32;
            r[i] = (ta[s] > tbv[s]);
            if (ta[s] == tbv[s]) t = 1'b1;
        end
    endfunction

    // Entered at a negedge with the DUT idle. start is held for hold_n
    // sampling edges; wiggle scrambles challenge every cycle; abort_bit >= 0
    // aborts during the SETTLE phase of that bit.
    task automatic run_eval(input logic [4:0] ch, input string tag, input int hold_n,
                            input bit wiggle, input int abort_bit);
        logic [RB-1:0] r;
        logic t;
        int cyc, k, ron, clr, dn, sel_bad, done_cyc;
        model(ch, r, t);
        start = 1'b1;
        challenge = ch;
        @(negedge clk);
        cyc = 1; k = 0; ron = 0; clr = 0; dn = 0; sel_bad = 0; done_cyc = 0;
        while (cyc < 2000) begin
            if (cyc >= hold_n) start = 1'b0;
            if (wiggle) challenge = 5'($urandom);
            if (cnt_clr) begin clr++; k++; end
            if (k > 0 && (sel_a != 5'(int'(ch) + k - 1) || sel_b != 5'(int'(ch) + k + 15)))
                sel_bad++;
            if (ro_en) ron++;
            if (abort_bit >= 0 && k == abort_bit + 1 && ron == WIN * k && !ro_en && !cnt_clr) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk({tag, "_abort_busy"}, busy, 0);
                chk({tag, "_abort_roen"}, ro_en, 0);
                chk({tag, "_abort_done"}, done, 0);
                chk({tag, "_abort_resp"}, response, exp_resp);
                chk({tag, "_abort_tie"}, tie, exp_tie);
                repeat (3) begin
                    @(negedge clk);
                    if (done || busy) dn++;
                end
                chk({tag, "_abort_quiet"}, dn, 0);
                return;
            end
            if (done) begin dn++; done_cyc = cyc; break; end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, dn, 1);
        chk({tag, "_done_cyc"}, done_cyc, DONE_CYC);
        chk({tag, "_roen_cycles"}, ron, RB * WIN);
        chk({tag, "_clr_cycles"}, clr, RB);
        chk({tag, "_sel_track"}, sel_bad, 0);
        chk({tag, "_response"}, response, r);
        chk({tag, "_tie"}, tie, t);
        exp_resp = r;
        exp_tie  = t;
        @(negedge clk);
        chk({tag, "_idle_after"}, busy, 0);
    endtask

    initial begin
        logic [4:0] c;

        // Reset state
        #1 rst_n = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_roen", ro_en, 0);
        chk("rst_clr", cnt_clr, 0);
        chk("rst_done", done, 0);
        chk("rst_resp", response, 0);
        chk("rst_tie", tie, 0);
        chk("rst_sel_a", sel_a, 0);
        chk("rst_sel_b", sel_b, 16);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);

        // Constant counts, challenge 3
        for (int i = 0; i < 32; i++) begin ta[i] = 8'd200; tbv[i] = 8'd100; end
        run_eval(5'd3, "dflt", 1, 1'b0, -1);
        chk("dflt_resp_ff", response, 8'hFF);

        // Reset mid-RUN
        start = 1'b1; challenge = 5'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("prerst_roen", ro_en, 1);
        #2 rst_n = 1'b1;
        #1;
        chk("midrst_roen", ro_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_resp", response, 0);
        chk("midrst_tie", tie, 0);
        chk("midrst_sel_a", sel_a, 0);
        chk("midrst_sel_b", sel_b, 16);
        chk("midrst_done", done, 0);
        exp_resp = '0; exp_tie = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);

        // Wrap: bit set only for even oscillators, challenge 30
        for (int i = 0; i < 32; i++) begin
            ta[i] = (i % 2 == 0) ? 8'd200 : 8'd100;
            tbv[i] = 8'd150;
        end
        run_eval(5'd30, "wrap", 1, 1'b0, -1);
        chk("wrap_resp_55", response, 8'h55);

        // Ties, then no ties
        for (int i = 0; i < 32; i++) begin ta[i] = 8'd50; tbv[i] = 8'd50; end
        run_eval(5'd7, "tie", 1, 1'b0, -1);
        chk("tie_set", tie, 1);
        for (int i = 0; i < 32; i++) ta[i] = 8'd51;
        run_eval(5'd7, "untie", 1, 1'b0, -1);
        chk("tie_clear", tie, 0);

        // Abort in SETTLE of bit 2, then a 3-cycle start accepted once
        for (int i = 0; i < 32; i++) begin ta[i] = 8'($urandom); tbv[i] = 8'($urandom); end
        run_eval(5'($urandom), "abort", 1, 1'b0, 2);
        run_eval(5'($urandom), "hold3", 3, 1'b0, -1);

        // abort together with start in IDLE: start is not accepted
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle", busy, 0);
        @(negedge clk);

        // Challenge scrambled during run with start held through DONE;
        // the following IDLE-cycle start must be accepted.
        run_eval(5'd17, "wiggle", 100000, 1'b1, -1);
        run_eval(5'd21, "after_done", 1, 1'b0, -1);

        // Randomized evaluations
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 32; i++) begin
                ta[i]  = 8'($urandom);
                tbv[i] = ($urandom_range(0, 3) == 0) ? ta[i] : 8'($urandom);
            end
            c = 5'($urandom);
            run_eval(c, "rand", 1, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ro_puf_ctrl.md
# ro_puf_ctrl

Challenge sequencer for the ring-oscillator PUF. It maps a 5-bit challenge onto RESP_BITS oscillator pairs and, for each pair, drives the two 32:1 oscillator select muxes. It clears and enables the two edge counters for a fixed window, then compares the frozen counts to form one response bit. It sits between the tile I/O and the two oscillator/mux/counter banks, replacing free-running counting with a deterministic, clock-timed measurement.

## Interface
- COUNT_W, 8, width of each oscillator edge counter
- WINDOW, 64, clk cycles the oscillators are enabled per bit (≥1)
- SETTLE, 4, clk cycles after disable before counts are compared (≥2, covers counter async domain)
- RESP_BITS, 8, response bits per challenge (1..32)

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-high
- start  in  1  begin evaluation; sampled only in IDLE
- abort  in  1  synchronous cancel; highest priority after reset
- challenge  in  5  base oscillator index, latched on accepted start
- count_a  in  COUNT_W  edge count from bank A
- count_b  in  COUNT_W  edge count from bank B
- ro_en  out  1  oscillator enable to both banks
- cnt_clr  out  1  counter clear to both banks
- sel_a  out  5  bank A oscillator select
- sel_b  out  5  bank B oscillator select
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, response/tie valid
- response  out  RESP_BITS  last completed response, held until next done
- tie  out  1  at least one pair compared equal in last completed evaluation

## Operation
- States: IDLE, CLEAR, RUN, SETTLE, COMPARE, DONE.
- IDLE: ro_en=0, cnt_clr=0. On start=1: latch challenge into ch_reg, idx=0, clear shift register and tie accumulator, go to CLEAR.
- CLEAR: cnt_clr=1 for exactly one cycle, ro_en=0, then RUN.
- RUN: ro_en=1 for exactly WINDOW cycles, counted by a window counter, then SETTLE.
- SETTLE: ro_en=0 for exactly SETTLE cycles, then COMPARE.
- COMPARE, one cycle:
  - bit = (count_a > count_b), unsigned, full COUNT_W.
  - Equal counts give bit=0 and set the tie accumulator.
  - Store bit at shift-register position idx.
  - If idx==RESP_BITS-1, go to DONE. Otherwise increment idx and go to CLEAR.
- DONE, one cycle: response ← shift register, tie ← accumulator, done=1, then IDLE.
- Selects, combinational from registers:
  - sel_a = (ch_reg + idx) mod 32
  - sel_b = (ch_reg + idx + 16) mod 32
  - sel_a≠sel_b always. Both wrap modulo 32.
- Selects are stable from CLEAR through COMPARE of each bit. They change only on the COMPARE→CLEAR transition.
- start while busy is ignored. challenge changes while busy have no effect.
- abort=1 in any non-IDLE state:
  - Next state is IDLE, ro_en=0, no done.
  - response and tie keep their previous values.
  - abort in IDLE has no effect. abort together with start in IDLE means abort wins, and start is not accepted.
- Counter wrap is not detected. Comparison uses raw wrapped values; WINDOW must be sized by integration.

## Timing
- Reset (async assert): state=IDLE, ro_en=0, cnt_clr=0, busy=0, done=0, response=0, tie=0, idx=0, ch_reg=0, so sel_a=0, sel_b=16. Asserting reset mid-evaluation aborts immediately, with no done.
- Per-bit cost: WINDOW+SETTLE+2 cycles.
- Accepted start at edge E0: CLEAR occupies cycle 1, and done is high in cycle RESP_BITS·(WINDOW+SETTLE+2)+1. Defaults: cycle 561. busy is high from cycle 1 through the DONE cycle inclusive.
- A start in the cycle after DONE (IDLE) is accepted. The minimum gap between done pulses is one IDLE cycle.
- All outputs are registered or decoded from registered state. They have no combinational path from inputs.

## Test plan
- Reset mid-RUN → ro_en drops asynchronously; busy=0, response=0, tie=0, sel_a=0, sel_b=16; no done.
- Defaults, challenge=5'd3, count_a=200, count_b=100 constant → done in cycle 561, response=8'hFF, tie=0. Per bit: ro_en high exactly 64 cycles, cnt_clr one cycle; sel_a steps 3..10 and sel_b steps 19..26.
- challenge=5'd30, RESP_BITS=8, count_a>count_b only when sel_a is even → sel_a visits 30,31,0..5 (wrap) and response=8'b01010101 (bit0=sel 30).
- count_a==count_b=50 for every bit → response=8'h00, tie=1. The next run with count_a=51 gives tie=0.
- abort asserted in SETTLE of bit 2 → IDLE next cycle, no done, response/tie unchanged. A start pulse held for 3 cycles during the next busy period is accepted only once.
- start held with challenge changing during the run → response reflects the challenge latched at acceptance; a second start asserted in the DONE cycle is ignored, and one asserted in the following IDLE cycle is accepted.
